// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode encodings,
// count-width helper and a status bundle for monitors.
package sync_fifo_pkg;

    localparam int MODE_REG  = 0;
    localparam int MODE_FWFT = 1;

    // One extra bit so occupancy can represent DEPTH itself.
    function automatic int cnt_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

    typedef struct packed {
        logic wfull;
        logic rempty;
        logic walmost_full;
        logic ralmost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_storage.sv
// Dual-port storage array: one gated write port, read port either
// combinational or registered (registered output resets to zero).
module fifo_storage #(
    parameter int DW     = 8,
    parameter int AW     = 4,
    parameter bit REG_RD = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    if (REG_RD) begin : g_reg
        logic [DW-1:0] r_rdata;

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_rdata <= '0;
            end else if (i_re) begin
                r_rdata <= r_mem[i_raddr];
            end
        end

        assign o_rdata = r_rdata;
    end else begin : g_comb
        logic w_unused;
        assign w_unused = &{1'b0, i_re, i_rst_n};
        assign o_rdata  = r_mem[i_raddr];
    end

endmodule

// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO with registered or first-word-fall-through read,
// occupancy/threshold flags and sticky overflow/underflow errors.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE         = 8,
    parameter int ADDRESS_SIZE  = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (1 << ADDRESS_SIZE) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic                    winc,
    input  logic [DSIZE-1:0]        wdata,
    input  logic                    rinc,
    output logic [DSIZE-1:0]        rdata,
    output logic                    rvalid,
    output logic                    wfull,
    output logic                    rempty,
    output logic                    walmost_full,
    output logic                    ralmost_empty,
    output logic [ADDRESS_SIZE:0]   count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clr_err
);

    localparam int DEPTH = 1 << ADDRESS_SIZE;
    localparam int CW    = cnt_width(ADDRESS_SIZE);
    localparam logic [CW-1:0] LP_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] LP_AFULL  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] LP_AEMPTY = CW'(AEMPTY_THRESH);

    if (ADDRESS_SIZE < 1) begin : g_bad_aw
        $error("sync_fifo_mem: ADDRESS_SIZE must be >= 1");
    end
    if (DSIZE < 1) begin : g_bad_dw
        $error("sync_fifo_mem: DSIZE must be >= 1");
    end
    if (FWFT != MODE_REG && FWFT != MODE_FWFT) begin : g_bad_mode
        $error("sync_fifo_mem: FWFT must be 0 or 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_mem: AFULL_THRESH out of range 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_mem: AEMPTY_THRESH out of range 0..DEPTH-1");
    end

    logic [CW-1:0]    r_wptr;
    logic [CW-1:0]    r_rptr;
    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             r_overflow;
    logic             r_underflow;
    logic [DSIZE-1:0] w_mem_rdata;

    // Binary pointers carry a wrap bit, so plain subtraction gives 0..DEPTH.
    assign w_count  = r_wptr - r_rptr;
    assign w_full   = (w_count == LP_DEPTH);
    assign w_empty  = (w_count == '0);
    assign w_wr_acc = winc && !w_full;
    assign w_rd_acc = rinc && !w_empty;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + CW'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + CW'(1);
            end
            r_overflow  <= (winc && w_full)  || (r_overflow  && !clr_err);
            r_underflow <= (rinc && w_empty) || (r_underflow && !clr_err);
        end
    end

    fifo_storage #(
        .DW     (DSIZE),
        .AW     (ADDRESS_SIZE),
        .REG_RD (FWFT == MODE_REG)
    ) u_storage (
        .i_clk   (wclk),
        .i_rst_n (wrst_n),
        .i_we    (w_wr_acc && wrst_n),
        .i_waddr (r_wptr[ADDRESS_SIZE-1:0]),
        .i_wdata (wdata),
        .i_re    (w_rd_acc),
        .i_raddr (r_rptr[ADDRESS_SIZE-1:0]),
        .o_rdata (w_mem_rdata)
    );

    if (FWFT == MODE_FWFT) begin : g_fwft
        // Mask stale array contents so an empty FIFO presents zero.
        assign rdata  = w_empty ? '0 : w_mem_rdata;
        assign rvalid = !w_empty;
    end else begin : g_regrd
        logic r_rvalid;

        always_ff @(posedge wclk) begin
            if (!wrst_n) begin
                r_rvalid <= 1'b0;
            end else begin
                r_rvalid <= w_rd_acc;
            end
        end

        assign rdata  = w_mem_rdata;
        assign rvalid = r_rvalid;
    end

    assign wfull         = w_full;
    assign rempty        = w_empty;
    assign walmost_full  = (w_count >= LP_AFULL);
    assign ralmost_empty = (w_count <= LP_AEMPTY);
    assign count         = w_count;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule

// File: tb/tb_sync_fifo_mem.sv
// Bench for sync_fifo_mem: registered and FWFT instances share stimulus and
// are compared every cycle against a queue-based model plus literal checks.
module tb_sync_fifo_mem;
    import sync_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, winc, rinc, clr_err;
    logic [7:0] wdata;

    logic [7:0] rd_r, rd_f;
    logic       rv_r, rv_f;
    logic       wfull_r, rempty_r, walm_r, ralm_r, ovf_r, unf_r;
    logic       wfull_f, rempty_f, walm_f, ralm_f, ovf_f, unf_f;
    logic [4:0] cnt_r, cnt_f;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sync_fifo_mem #(.DSIZE(8), .ADDRESS_SIZE(4), .FWFT(0)) u_reg (
        .wclk(clk), .wrst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rd_r), .rvalid(rv_r), .wfull(wfull_r), .rempty(rempty_r),
        .walmost_full(walm_r), .ralmost_empty(ralm_r), .count(cnt_r),
        .overflow(ovf_r), .underflow(unf_r), .clr_err(clr_err)
    );

    sync_fifo_mem #(.DSIZE(8), .ADDRESS_SIZE(4), .FWFT(1)) u_fwft (
        .wclk(clk), .wrst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rd_f), .rvalid(rv_f), .wfull(wfull_f), .rempty(rempty_f),
        .walmost_full(walm_f), .ralmost_empty(ralm_f), .count(cnt_f),
        .overflow(ovf_f), .underflow(unf_f), .clr_err(clr_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a queue of stored words plus sticky error bits.
    logic [7:0] q[$];
    bit         m_known = 0;
    bit         m_ov, m_un, m_rv;
    logic [7:0] m_rd;
    bit         m_full, m_empty;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_ov = 0; m_un = 0; m_rv = 0; m_rd = 8'h00;
            m_known = 1;
        end else if (m_known) begin
            m_full  = (q.size() == 16);
            m_empty = (q.size() == 0);
            m_rv = rinc && !m_empty;
            if (m_rv) m_rd = q.pop_front();
            if (winc && !m_full) q.push_back(wdata);
            m_ov = (winc && m_full)  || (m_ov && !clr_err);
            m_un = (rinc && m_empty) || (m_un && !clr_err);
        end
    end

    fifo_status_t exp_st, st_r, st_f;
    always @(negedge clk) begin
        if (m_known) begin
            exp_st = '{wfull: q.size() == 16, rempty: q.size() == 0,
                       walmost_full: q.size() >= 14, ralmost_empty: q.size() <= 2,
                       overflow: m_ov, underflow: m_un};
            st_r = '{wfull_r, rempty_r, walm_r, ralm_r, ovf_r, unf_r};
            st_f = '{wfull_f, rempty_f, walm_f, ralm_f, ovf_f, unf_f};
            chk("cmp_count_reg",  32'(cnt_r), 32'(q.size()));
            chk("cmp_count_fwft", 32'(cnt_f), 32'(q.size()));
            chk("cmp_status_reg",  32'(st_r), 32'(exp_st));
            chk("cmp_status_fwft", 32'(st_f), 32'(exp_st));
            chk("cmp_rvalid_reg", 32'(rv_r), 32'(m_rv));
            chk("cmp_rdata_reg",  32'(rd_r), 32'(m_rd));
            chk("cmp_rvalid_fwft", 32'(rv_f), 32'(q.size() != 0));
            chk("cmp_rdata_fwft",  32'(rd_f), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        end
    end

    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        winc = w; wdata = d; rinc = r; clr_err = c;
        @(posedge clk);
        #1;
        winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    int wp;

    initial begin
        rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_count", 32'(cnt_r), 0);
        chk("rst_rempty", 32'(rempty_r), 1);
        chk("rst_wfull", 32'(wfull_r), 0);
        chk("rst_ralmost", 32'(ralm_r), 1);
        chk("rst_walmost", 32'(walm_r), 0);
        chk("rst_rdata", 32'(rd_r), 0);
        chk("rst_rvalid", 32'(rv_r), 0);
        chk("rst_rvalid_fwft", 32'(rv_f), 0);
        chk("rst_errs", 32'({ovf_r, unf_r}), 0);

        // Fill to full, then overflow attempt.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 12) chk("afull_at13", 32'(walm_r), 0);
            if (i == 13) chk("afull_at14", 32'(walm_r), 1);
        end
        chk("full_flag", 32'(wfull_r), 1);
        chk("full_count", 32'(cnt_r), 16);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf_r), 1);
        chk("ovf_count", 32'(cnt_r), 16);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(ovf_r), 0);

        // Drain in order.
        for (int i = 0; i < 16; i++) begin
            chk("fwft_head", 32'(rd_f), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_data", 32'(rd_r), 32'(i));
            chk("drain_valid", 32'(rv_r), 1);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rvalid_pulse", 32'(rv_r), 0);
        chk("drain_empty", 32'(rempty_r), 1);
        chk("rdata_hold", 32'(rd_r), 32'h0F);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_set", 32'(unf_r), 1);
        chk("unf_noread", 32'(rv_r), 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("unf_clr", 32'(unf_r), 0);

        // Full with simultaneous write and read.
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("fullrw_rdata", 32'(rd_r), 32'h00);
        chk("fullrw_count", 32'(cnt_r), 15);
        chk("fullrw_ovf", 32'(ovf_r), 1);
        cyc(1'b1, 8'hAA, 1'b0, 1'b1);
        chk("fullrw_refill", 32'(cnt_r), 16);
        chk("fullrw_ovf_clr", 32'(ovf_r), 0);

        // Empty with simultaneous write and read.
        do_reset();
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk("emptyrw_unf", 32'(unf_f), 1);
        chk("emptyrw_rdata_fwft", 32'(rd_f), 32'h55);
        chk("emptyrw_rvalid_fwft", 32'(rv_f), 1);
        chk("emptyrw_count", 32'(cnt_r), 1);
        chk("emptyrw_rvalid_reg", 32'(rv_r), 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Steady streaming at count 5 across pointer wrap.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'(i), 1'b1, 1'b0);
            chk("stream_count", 32'(cnt_r), 5);
            chk("stream_data", 32'(rd_r), (i < 5) ? 32'(8'h80 + i) : 32'(i - 5));
        end

        // Reset with a registered read in flight.
        do_reset();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(cnt_r), 9);
        chk("pre_rst_rvalid", 32'(rv_r), 1);
        rst_n = 1'b0;
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        rst_n = 1'b1;
        chk("midrst_count", 32'(cnt_r), 0);
        chk("midrst_rempty", 32'(rempty_r), 1);
        chk("midrst_rvalid", 32'(rv_r), 0);
        chk("midrst_rdata", 32'(rd_r), 0);
        chk("midrst_errs", 32'({ovf_r, unf_r}), 0);
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("postrst_fwft", 32'(rd_f), 32'h3C);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("postrst_reg", 32'(rd_r), 32'h3C);

        // Randomised traffic, alternating write- and read-biased phases.
        for (int ph = 0; ph < 4; ph++) begin
            wp = (ph % 2 == 0) ? 75 : 25;
            for (int k = 0; k < 500; k++) begin
                rst_n = ($urandom_range(499) != 0);
                cyc($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < (100 - wp),
                    $urandom_range(15) == 0);
            end
        end
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_mem.md
Name: sync_fifo_mem

Overview:
- Single-clock successor to the FIFO storage element: parametrised width and depth, with built-in pointer management and a selectable read mode.
- Read mode is either registered (standard) or first-word-fall-through (FWFT).
- Provides full, empty, almost-full and almost-empty flags, an occupancy count, and sticky overflow/underflow error flags.
- Used wherever producer and consumer share one clock domain, and as the golden single-clock model for async FIFO comparison benches.

Parameters:
- DSIZE, 8, data word width in bits.
- ADDRESS_SIZE, 4, address width; DEPTH = 2**ADDRESS_SIZE entries.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-2, walmost_full asserts when count >= this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 2, ralmost_empty asserts when count <= this value; legal range 0..DEPTH-1.

Ports:
- wclk  input  1  sole clock; all state updates on its rising edge.
- wrst_n  input  1  reset; synchronous, active-low.
- winc  input  1  write request.
- wdata  input  DSIZE  write data.
- rinc  input  1  read request (FWFT=1: pop the currently presented word).
- rdata  output  DSIZE  read data.
- rvalid  output  1  rdata qualifier.
- wfull  output  1  count == DEPTH.
- rempty  output  1  count == 0.
- walmost_full  output  1  count >= AFULL_THRESH.
- ralmost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  ADDRESS_SIZE+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.
- clr_err  input  1  clears overflow and underflow.

Behaviour:
- Reset (wrst_n=0 at a wclk edge):
  - wptr, rptr, count = 0; rempty=1; wfull=0; ralmost_empty=1; walmost_full=0.
  - rdata=0; rvalid=0; overflow=0; underflow=0.
  - Storage array is not reset; its contents are logically discarded.
  - Reset applied mid-operation abandons all queued data, including any registered read in flight.
- Pointers are ADDRESS_SIZE+1 bits, binary, and wrap naturally modulo 2*DEPTH.
  - Storage is addressed with the low ADDRESS_SIZE bits.
  - count = wptr - rptr, computed modulo 2**(ADDRESS_SIZE+1).
- All flags and count are combinational decodes of the registered pointers. They reflect a transfer in the cycle after the accepting edge.
- Write accept: winc && !wfull. Store wdata at wptr, then wptr+1.
- Read accept: rinc && !rempty. Then rptr+1.
- Acceptance always uses start-of-cycle flags:
  - Full with simultaneous winc and rinc: read accepted, write rejected (counts as overflow). count goes DEPTH -> DEPTH-1.
  - Empty with simultaneous winc and rinc: write accepted, read rejected (counts as underflow). count goes 0 -> 1.
  - Otherwise simultaneous accepted read and write: count unchanged.
- FWFT=0:
  - On an accepted read, rdata <= mem[rptr] at the same edge; rvalid=1 for exactly that following cycle.
  - Read latency 1 cycle. rdata holds its last value when no read is accepted.
- FWFT=1:
  - rdata = mem[rptr] combinationally; rvalid = !rempty.
  - The first write into an empty FIFO is visible on rdata one cycle after its edge.
  - rinc consumes the presented word.
- Sticky error flags:
  - overflow set on winc && wfull; underflow set on rinc && rempty.
  - Both cleared by clr_err. If set and clear occur in the same cycle, set wins.
- Rejected operations never modify pointers or storage.
- Parameter legality is checked at elaboration with assertions.

Decomposition:
- Package sync_fifo_pkg holds:
  - Read-mode localparams (MODE_REG=0, MODE_FWFT=1).
  - A width helper function for the count width.
  - A packed status struct fifo_status_t {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow} for bench monitors.
- One sub-module, fifo_storage: parametrised dual-port array.
  - Write port gated by a single write-enable.
  - Read port combinational or registered by parameter.
  - The top level owns pointers, flags and errors.

Test Plan:
- Reset, then write 16 words 0x00..0x0F with DEPTH=16 -> wfull=1 and count=16 after the 16th edge; walmost_full=1 from count=14; 17th winc -> overflow=1, storage and count unchanged.
- Drain the full FIFO with FWFT=0 -> rdata sequence 0x00..0x0F, each one cycle after its rinc with a one-cycle rvalid pulse; rempty=1 after the last read; extra rinc -> underflow=1.
- Full FIFO with simultaneous winc (0xAA) and rinc -> read returns 0x00, write rejected, count=15, overflow=1; the following single write of 0xAA is accepted.
- Empty FIFO with simultaneous winc (0x55) and rinc, FWFT=1 -> write accepted, underflow=1, rdata=0x55 and rvalid=1 next cycle.
- Stream 40 words with a continuous simultaneous write and read at count=5 -> pointers wrap, data order preserved, count stays 5.
- Assert wrst_n=0 with count=9 and a registered read pending -> next cycle count=0, rempty=1, rvalid=0, rdata=0, error flags cleared; the first post-reset write reads back correctly.
